// File: rtl/lsu_pkg.sv
// Purpose: shared types, funct3 encodings and access-size helpers for the load/store sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-lane mask of an access at lane offset 0; funct3[1:0] encodes log2(size).
  function automatic logic [7:0] lane_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // An access is misaligned when any offset bit below its natural size is set.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Purpose: byte-lane extraction/extension for loads and lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none.
// Ports: dword (doubleword from memory/buffer), offset (addr[2:0]), funct3, wdata (store data)
//        -> load_val (extended load result), store_dw (dword with selected lanes replaced).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  output logic [63:0] load_val,
  output logic [63:0] store_dw
);

  logic [63:0] shifted;
  logic [63:0] wd_shift;
  logic [63:0] bit_mask;
  logic [7:0]  lane_mask;

  always_comb begin
    // Little-endian: lane k lives at bits 8k+7:8k, so shift the target lane down to bit 0.
    shifted = dword >> {offset, 3'b000};
    case (funct3[1:0])
      2'd0:    load_val = funct3[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = funct3[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = funct3[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    lane_mask = lane_bytes(funct3) << offset;
    bit_mask  = '0;
    for (int k = 0; k < 8; k++) begin
      bit_mask[8*k +: 8] = {8{lane_mask[k]}};
    end
    wd_shift = wdata << {offset, 3'b000};
    // A doubleword access has a full mask, so the result is wdata regardless of dword.
    store_dw = (dword & ~bit_mask) | (wd_shift & bit_mask);
  end

endmodule

// File: rtl/lsu_seq.sv
// Purpose: load/store sequencer between the multicycle control unit and 64-bit data memory.
// Latency: load MEM_LAT+1, sd 2, sb/sh/sw MEM_LAT+2, illegal access 1 cycle (accept edge to done).
// Backpressure: one access at a time; req is ignored (not queued) while busy.
// Ports: clk, rst (async active-low); req/we/funct3/addr/wdata request; busy/done/err/rdata status;
//        mem_addr/mem_wdata/mem_wr/mem_rdata doubleword memory interface.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] buf_q;
  logic        err_q;
  logic        accept;
  logic        illegal;
  logic        rd_last;
  logic [63:0] lane_dw;
  logic [63:0] load_val;
  logic [63:0] store_dw;

  assign accept  = (state == IDLE) && req;
  assign illegal = (we ? funct3[2] : (funct3 == 3'b111)) || misaligned(funct3, addr[2:0]);
  assign rd_last = (state == RD) && (cnt == 3'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) begin
        if (illegal)                       state_nxt = DONE;
        else if (we && funct3[1:0] == 2'd3) state_nxt = WR;
        else                               state_nxt = RD;
      end
      RD:   if (cnt == 3'd0) state_nxt = we_q ? WR : DONE;
      WR:   state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces IDLE so mem_wr drops without a clock edge.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    mem_wr    = (state == WR);
    mem_wdata = (state == WR) ? store_dw : '0;
  end

  // During RD the lane unit sees live memory data so rdata can be loaded on the capture edge;
  // in WR it merges into the captured buffer.
  assign lane_dw = (state == RD) ? mem_rdata : buf_q;

  lsu_lane u_lane (
    .dword    (lane_dw),
    .offset   (off_q),
    .funct3   (f3_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .store_dw (store_dw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        f3_q    <= funct3;
        off_q   <= addr[2:0];
        wdata_q <= wdata;
        err_q   <= illegal;
        cnt     <= 3'(MEM_LAT - 1);
        // An illegal access touches no memory, so the address port keeps its last value.
        if (!illegal) mem_addr <= {addr[63:3], 3'b000};
      end
      if (state == RD && !rd_last) cnt <= cnt - 3'd1;
      if (rd_last) begin
        buf_q <= mem_rdata;
        if (!we_q) rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Purpose: self-checking bench for lsu_seq with a byte-level reference model and randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_seq;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance
  logic        req, we, busy, done, err, mem_wr;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  // MEM_LAT=3 instance
  logic        req3, we3, busy3, done3, err3, mem_wr3;
  logic [2:0]  funct3_3;
  logic [63:0] addr3, wdata3, rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [63:0] mem     [0:31];
  logic [63:0] ref_mem [0:31];
  logic [63:0] d3      [0:1];
  logic [63:0] exp_rdata;
  int checks = 0;
  int errors = 0;

  lsu_seq #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  lsu_seq #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .funct3(funct3_3), .addr(addr3), .wdata(wdata3),
    .busy(busy3), .done(done3), .err(err3), .rdata(rdata3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3)
  );

  // Latency-1 memory: data for the presented address is available within the RD cycle.
  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[7:3]] <= mem_wdata;

  // Latency-3 memory: two register stages, so stale data shows up if captured early.
  always @(posedge clk) begin
    d3[0] <= mem[mem_addr3[7:3]];
    d3[1] <= d3[0];
  end
  assign mem_rdata3 = d3[1];

  // ---------------- reference model ----------------
  function automatic logic model_bad(input logic w, input logic [2:0] f3, input logic [63:0] a);
    int n;
    if (w ? f3[2] : (f3 == 3'b111)) return 1'b1;
    n = 1 << f3[1:0];
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic int model_lat(input logic w, input logic [2:0] f3, input logic [63:0] a, input int lat);
    if (model_bad(w, f3, a)) return 1;
    if (!w) return lat + 1;
    if (f3[1:0] == 2'd3) return 2;
    return lat + 2;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] dw, input logic [63:0] a, input logic [2:0] f3);
    logic [63:0] v;
    int n, off;
    n = 1 << f3[1:0];
    off = int'(a[2:0]);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] dw, input logic [63:0] a,
                                              input logic [2:0] f3, input logic [63:0] wd);
    logic [63:0] r;
    int n, off;
    n = 1 << f3[1:0];
    off = int'(a[2:0]);
    r = dw;
    for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- driver: one access on the MEM_LAT=1 instance ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                       output int lat, output logic e, output logic [63:0] rd, output int nwr,
                       output int wr_cyc, output logic [63:0] wdw, output logic busy_after);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    we = 1'($urandom); funct3 = 3'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    lat = 99; e = 1'b0; rd = '0; nwr = 0; wr_cyc = 0; wdw = '0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_wr) begin nwr++; wr_cyc = c; wdw = mem_wdata; end
      if (done) begin lat = c; e = err; rd = rdata; break; end
      @(negedge clk);
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, err, mem_wr} !== 4'b0000)
      begin errors++; $display("FAIL reset_ctrl: busy/done/err/mem_wr=%b expected 0000", {busy, done, err, mem_wr}); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    rst = 1'b1;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [63:0] a_t  [5] = '{64'h10, 64'h17, 64'h17, 64'h16, 64'h14};
    logic [2:0]  f_t  [5] = '{F3_D, F3_B, F3_BU, F3_H, F3_WU};
    logic [63:0] ex_t [5] = '{64'h8877665544332211, 64'hFFFFFFFFFFFFFF88, 64'h0000000000000088,
                              64'hFFFFFFFFFFFF8877, 64'h0000000088776655};
    int lat, nwr, wc; logic e, ba; logic [63:0] rd, wdw;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, f_t[i], a_t[i], 64'd0, lat, e, rd, nwr, wc, wdw, ba);
      checks++; if (lat !== 2) begin errors++; $display("FAIL load%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (rd !== ex_t[i]) begin errors++; $display("FAIL load%0d_rdata: got %h expected %h", i, rd, ex_t[i]); end
      checks++; if (e !== 1'b0 || nwr !== 0)
        begin errors++; $display("FAIL load%0d_err_wr: err=%b writes=%0d expected 0/0", i, e, nwr); end
      exp_rdata = ex_t[i];
    end
  endtask

  task automatic test_stores();
    int lat, nwr, wc; logic e, ba; logic [63:0] rd, wdw;
    do_op(1'b1, F3_H, 64'h12, 64'h12345678AAAABBBB, lat, e, rd, nwr, wc, wdw, ba);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", lat); end
    checks++; if (nwr !== 1 || wc !== 2) begin errors++; $display("FAIL sh_write: count=%0d cycle=%0d expected 1/2", nwr, wc); end
    checks++; if (wdw !== 64'h88776655BBBB2211) begin errors++; $display("FAIL sh_wdata: got %h expected 88776655bbbb2211", wdw); end
    checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL sh_rdata_hold: got %h expected %h", rd, exp_rdata); end
    ref_mem[2] = 64'h88776655BBBB2211;
    do_op(1'b1, F3_D, 64'h10, 64'hDEADBEEFCAFEF00D, lat, e, rd, nwr, wc, wdw, ba);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sd_latency: got %0d expected 2", lat); end
    checks++; if (nwr !== 1 || wc !== 1) begin errors++; $display("FAIL sd_write: count=%0d cycle=%0d expected 1/1", nwr, wc); end
    checks++; if (wdw !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL sd_wdata: got %h expected deadbeefcafef00d", wdw); end
    do_op(1'b1, F3_D, 64'h10, 64'h8877665544332211, lat, e, rd, nwr, wc, wdw, ba);
    checks++; if (mem[2] !== 64'h8877665544332211) begin errors++; $display("FAIL sd_restore: mem got %h expected 8877665544332211", mem[2]); end
    ref_mem[2] = 64'h8877665544332211;
  endtask

  task automatic test_errors();
    logic        w_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f_t [4] = '{F3_W, 3'b100, 3'b111, F3_D};
    logic [63:0] a_t [4] = '{64'h12, 64'h10, 64'h10, 64'h14};
    int lat, nwr, wc; logic e, ba; logic [63:0] rd, wdw;
    for (int i = 0; i < 4; i++) begin
      do_op(w_t[i], f_t[i], a_t[i], 64'h0123456789ABCDEF, lat, e, rd, nwr, wc, wdw, ba);
      checks++; if (lat !== 1) begin errors++; $display("FAIL err%0d_latency: got %0d expected 1", i, lat); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b expected 1", i, e); end
      checks++; if (nwr !== 0) begin errors++; $display("FAIL err%0d_nowrite: got %0d writes expected 0", i, nwr); end
      checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL err%0d_rdata_hold: got %h expected %h", i, rd, exp_rdata); end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone, nwr;
    req = 1'b1; we = 1'b0; funct3 = F3_D; addr = 64'h10;
    @(posedge clk);
    @(negedge clk);
    ndone = 0; nwr = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done) ndone++;
      if (mem_wr) nwr++;
      if (c == 1) begin we = 1'b1; funct3 = F3_D; addr = 64'h18; wdata = 64'h5555; end
      if (c == 2) req = 1'b0;
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ignore_done: got %0d done pulses expected 1", ndone); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL busy_ignore_write: got %0d writes expected 0", nwr); end
    checks++; if (rdata !== 64'h8877665544332211) begin errors++; $display("FAIL busy_ignore_rdata: got %h expected 8877665544332211", rdata); end
    exp_rdata = 64'h8877665544332211;
  endtask

  task automatic test_lat3();
    logic [63:0] a;
    int lat;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 64'h10 : 64'h18;
      req3 = 1'b1; we3 = 1'b0; funct3_3 = F3_D; addr3 = a; wdata3 = '0;
      @(posedge clk);
      @(negedge clk);
      req3 = 1'b0;
      lat = 99;
      for (int c = 1; c <= 20; c++) begin
        if (done3) begin lat = c; break; end
        @(negedge clk);
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL lat3_%0d_latency: got %0d expected 4", k, lat); end
      checks++; if (rdata3 !== ref_mem[a[7:3]] || err3 !== 1'b0)
        begin errors++; $display("FAIL lat3_%0d_rdata: got %h err=%b expected %h err=0", k, rdata3, err3, ref_mem[a[7:3]]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_op();
    int nwr, lat, wn, wc; logic e, ba; logic [63:0] rd, wdw;
    // Reset while reading.
    req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 64'h11; wdata = 64'hA5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_rd_busy_before: got %b expected 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL rst_rd_async: busy=%b mem_wr=%b expected 0/0", busy, mem_wr); end
    nwr = 0;
    repeat (3) begin @(negedge clk); if (mem_wr) nwr++; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (mem_wr) nwr++; end
    exp_rdata = '0;
    checks++; if (nwr !== 0) begin errors++; $display("FAIL rst_rd_nowrite: got %0d writes expected 0", nwr); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL rst_rd_rdata: got %h expected 0", rdata); end
    // Reset while the write strobe is up.
    req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 64'h11; wdata = 64'hA5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rst_wr_strobe_before: got %b expected 1", mem_wr); end
    rst = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_wr_async: mem_wr=%b expected 0", mem_wr); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem[2] !== 64'h8877665544332211) begin errors++; $display("FAIL rst_mem_intact: got %h expected 8877665544332211", mem[2]); end
    do_op(1'b0, F3_D, 64'h10, 64'd0, lat, e, rd, wn, wc, wdw, ba);
    checks++; if (rd !== 64'h8877665544332211 || lat !== 2)
      begin errors++; $display("FAIL rst_reread: rdata=%h lat=%0d expected 8877665544332211/2", rd, lat); end
    exp_rdata = rd;
  endtask

  task automatic test_random();
    logic w, e, ba, bad; logic [2:0] f3; logic [63:0] a, wd, rd, wdw, exp_ld, exp_st;
    int lat, nwr, wc, elat;
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom);
      a  = {56'd0, 8'($urandom)};
      if ($urandom_range(3) != 0) a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
      wd = {$urandom, $urandom};
      bad    = model_bad(w, f3, a);
      elat   = model_lat(w, f3, a, 1);
      exp_ld = (bad || w) ? exp_rdata : model_load(ref_mem[a[7:3]], a, f3);
      exp_st = model_store(ref_mem[a[7:3]], a, f3, wd);
      do_op(w, f3, a, wd, lat, e, rd, nwr, wc, wdw, ba);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency: we=%b f3=%0d a=%h got %0d expected %0d", n, w, f3, a, lat, elat); end
      checks++; if (e !== bad) begin errors++; $display("FAIL rnd%0d_err: we=%b f3=%0d a=%h got %b expected %b", n, w, f3, a, e, bad); end
      checks++; if (rd !== exp_ld) begin errors++; $display("FAIL rnd%0d_rdata: we=%b f3=%0d a=%h got %h expected %h", n, w, f3, a, rd, exp_ld); end
      checks++; if (nwr !== ((w && !bad) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_writes: got %0d expected %0d", n, nwr, (w && !bad) ? 1 : 0); end
      if (w && !bad) begin
        checks++; if (wdw !== exp_st) begin errors++; $display("FAIL rnd%0d_wdata: f3=%0d a=%h got %h expected %h", n, f3, a, wdw, exp_st); end
        ref_mem[a[7:3]] = exp_st;
      end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_after: busy=%b expected 0", n, ba); end
      exp_rdata = exp_ld;
    end
    for (int i = 0; i < 32; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL final_mem%0d: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    req3 = 1'b0; we3 = 1'b0; funct3_3 = '0; addr3 = '0; wdata3 = '0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[2] = 64'h8877665544332211;
    mem[3] = ~mem[2];
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_busy_ignore();
    test_lat3();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
